// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a 4-digit 7-seg display.
// Ports: clk, reset (async, active-high), enable, load, value[15:0] (BCD),
//   dp_in[3:0] -> hex[3:0], an[3:0] (active-low), dp (active-low),
//   busy, frame_done (1-cycle pulse), err (sticky non-BCD flag).
module seg_scan_ctrl #(
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 1000,
    parameter int LZB          = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [3:0]  hex,
    output logic [3:0]  an,
    output logic        dp,
    output logic        busy,
    output logic        frame_done,
    output logic        err
);

    localparam int CMAX = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES
                                                       : BLANK_CYCLES;
    localparam int CW = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_n;
    logic [1:0]      r_idx;
    logic [1:0]      w_idx_n;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_n;

    logic [15:0]     r_shadow;
    logic [3:0]      r_sdp;
    logic [15:0]     r_pend;
    logic [3:0]      r_pdp;
    logic [15:0]     w_shadow_n;
    logic [3:0]      w_sdp_n;

    logic [3:0]      r_hex;
    logic [3:0]      r_an;
    logic            r_dp;
    logic            r_busy;
    logic            r_frame_done;
    logic            r_err;

    logic [3:0]      w_hex_n;
    logic [3:0]      w_an_n;
    logic            w_dp_n;

    logic            w_frame_end;
    logic            w_xfer;
    logic            w_take;

    function automatic logic [3:0] f_nib(input logic [15:0] v,
                                         input logic [1:0]  i);
        return v[{i, 2'b00} +: 4];
    endfunction

    function automatic logic f_bad(input logic [15:0] v);
        return (v[15:12] > 4'd9) || (v[11:8] > 4'd9) ||
               (v[7:4]   > 4'd9) || (v[3:0]  > 4'd9);
    endfunction

    // Dark = non-BCD nibble, or a leading zero (digit 0 always shown).
    function automatic logic f_dark(input logic [15:0] v,
                                    input logic [1:0]  i);
        logic lz;
        unique case (i)
            2'd3:    lz = (v[15:12] == 4'd0);
            2'd2:    lz = (v[15:8]  == 8'd0);
            2'd1:    lz = (v[15:4]  == 12'd0);
            default: lz = 1'b0;
        endcase
        return (f_nib(v, i) > 4'd9) || ((LZB != 0) && lz);
    endfunction

    // Frame boundary: leaving the last SHOW cycle of digit 3 while enabled.
    assign w_frame_end = (r_state == SHOW) && (r_cnt == SLOT_LAST) &&
                         (r_idx == 2'd3) && enable;
    assign w_xfer      = (r_state == IDLE) || w_frame_end;
    assign w_take      = w_xfer && (load || r_busy);

    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        w_cnt_n   = r_cnt;
        if (!enable) begin
            w_state_n = IDLE;
            w_idx_n   = 2'd0;
            w_cnt_n   = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_n = BLANK;
                    w_idx_n   = 2'd0;
                    w_cnt_n   = '0;
                end
                BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_state_n = SHOW;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (r_cnt == SLOT_LAST) begin
                        w_state_n = BLANK;
                        w_idx_n   = r_idx + 2'd1;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_n = IDLE;
                    w_idx_n   = 2'd0;
                    w_cnt_n   = '0;
                end
            endcase
        end
    end

    // A load on a transfer edge bypasses the pending register.
    always_comb begin
        w_shadow_n = r_shadow;
        w_sdp_n    = r_sdp;
        if (w_xfer && load) begin
            w_shadow_n = value;
            w_sdp_n    = dp_in;
        end else if (w_xfer && r_busy) begin
            w_shadow_n = r_pend;
            w_sdp_n    = r_pdp;
        end
    end

    // Outputs are derived from next-state values so they line up with it.
    always_comb begin
        w_an_n  = 4'b1111;
        w_dp_n  = 1'b1;
        w_hex_n = 4'd0;
        unique case (w_state_n)
            BLANK: w_hex_n = f_nib(w_shadow_n, w_idx_n);
            SHOW: begin
                w_hex_n = f_nib(w_shadow_n, w_idx_n);
                if (!f_dark(w_shadow_n, w_idx_n)) begin
                    w_an_n = ~(4'b0001 << w_idx_n);
                    w_dp_n = ~w_sdp_n[w_idx_n];
                end
            end
            default: begin
                w_an_n  = 4'b1111;
                w_dp_n  = 1'b1;
                w_hex_n = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_idx        <= 2'd0;
            r_cnt        <= '0;
            r_shadow     <= 16'd0;
            r_sdp        <= 4'd0;
            r_pend       <= 16'd0;
            r_pdp        <= 4'd0;
            r_hex        <= 4'd0;
            r_an         <= 4'b1111;
            r_dp         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_idx        <= w_idx_n;
            r_cnt        <= w_cnt_n;
            r_shadow     <= w_shadow_n;
            r_sdp        <= w_sdp_n;
            r_hex        <= w_hex_n;
            r_an         <= w_an_n;
            r_dp         <= w_dp_n;
            r_frame_done <= w_frame_end;
            if (w_xfer) begin
                r_busy <= 1'b0;
            end else if (load) begin
                r_pend <= value;
                r_pdp  <= dp_in;
                r_busy <= 1'b1;
            end
            if (w_take) begin
                r_err <= f_bad(w_shadow_n);
            end
        end
    end

    assign hex        = r_hex;
    assign an         = r_an;
    assign dp         = r_dp;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign err        = r_err;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with a frame-time model.
// Ports: none; drives all DUT inputs and prints one summary line.
module tb_seg_scan_ctrl;

    localparam int SL = 4;
    localparam int BL = 2;
    localparam int PS = SL + BL;
    localparam int FR = 4 * PS;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  hex;
    logic [3:0]  an;
    logic        dp;
    logic        busy;
    logic        frame_done;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Model: scan position expressed as time since enable.
    bit          m_run;
    int          m_t;
    logic [15:0] m_sh;
    logic [3:0]  m_sdp;
    logic [15:0] m_pend;
    logic [3:0]  m_pdp;
    bit          m_busy;
    bit          m_err;
    bit          m_fd;

    seg_scan_ctrl #(
        .SLOT_CYCLES (SL),
        .BLANK_CYCLES(BL),
        .LZB         (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .value     (value),
        .dp_in     (dp_in),
        .hex       (hex),
        .an        (an),
        .dp        (dp),
        .busy      (busy),
        .frame_done(frame_done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h",
                     nm, $time, act, exp);
        end
    endtask

    function automatic bit non_bcd(input logic [15:0] v);
        for (int k = 0; k < 4; k++) begin
            if (((v >> (4 * k)) & 16'hF) > 16'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_run  = 0;
        m_t    = 0;
        m_sh   = 16'd0;
        m_sdp  = 4'd0;
        m_pend = 16'd0;
        m_pdp  = 4'd0;
        m_busy = 0;
        m_err  = 0;
        m_fd   = 0;
    endtask

    task automatic model_update();
        bit bnd;
        bit xf;
        bnd = m_run && ((m_t % FR) == FR - 1);
        xf  = !m_run || (enable && bnd);
        if (xf) begin
            if (load) begin
                m_sh  = value;
                m_sdp = dp_in;
                m_err = non_bcd(value);
            end else if (m_busy) begin
                m_sh  = m_pend;
                m_sdp = m_pdp;
                m_err = non_bcd(m_pend);
            end
            m_busy = 0;
        end else if (load) begin
            m_pend = value;
            m_pdp  = dp_in;
            m_busy = 1;
        end
        m_fd = enable && bnd;
        if (!enable) begin
            m_run = 0;
        end else if (!m_run) begin
            m_run = 1;
            m_t   = 0;
        end else begin
            m_t++;
        end
    endtask

    task automatic exp_out(output logic [3:0] ea, output logic [3:0] eh,
                           output logic ed);
        int          pos;
        int          d;
        int          w;
        logic [15:0] up;
        bit          dark;
        ea = 4'b1111;
        eh = 4'd0;
        ed = 1'b1;
        if (m_run) begin
            pos  = m_t % FR;
            d    = pos / PS;
            w    = pos % PS;
            up   = m_sh >> (4 * d);
            eh   = up[3:0];
            dark = (up[3:0] > 4'd9) || (d > 0 && up == 16'd0);
            if (w >= BL && !dark) begin
                ea = ~(4'b0001 << d);
                ed = ~m_sdp[d];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else model_update();
        #1;
    endtask

    task automatic wait_pos(input int p);
        int n;
        n = 0;
        while (!(m_run && (m_t % FR) == p) && n < 3 * FR) begin
            step();
            n++;
        end
        if (!(m_run && (m_t % FR) == p)) begin
            checks++;
            errors++;
            $display("FAIL wait_pos timeout: got pos %0d required %0d",
                     m_t % FR, p);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    initial begin
        logic [3:0] ea;
        logic [3:0] eh;
        logic       ed;
        forever begin
            @(negedge clk);
            exp_out(ea, eh, ed);
            chk("cyc_an", 16'(an), 16'(ea));
            chk("cyc_hex", 16'(hex), 16'(eh));
            chk("cyc_dp", 16'(dp), 16'(ed));
            chk("cyc_busy", 16'(busy), 16'(m_busy));
            chk("cyc_fd", 16'(frame_done), 16'(m_fd));
            chk("cyc_err", 16'(err), 16'(m_err));
        end
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        load   = 1'b0;
        value  = 16'd0;
        dp_in  = 4'd0;
        model_reset();
        step();
        step();
        chk("rst_an", 16'(an), 16'h000F);
        chk("rst_hex", 16'(hex), 16'h0);
        chk("rst_dp", 16'(dp), 16'h1);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_fd", 16'(frame_done), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        reset = 1'b0;
        step();

        // First frame of 1234.
        enable = 1'b1;
        do_load(16'h1234, 4'b0000);
        chk("f0_blank_an", 16'(an), 16'h000F);
        chk("f0_blank_hex", 16'(hex), 16'h4);
        step();
        step();
        chk("f0_d0_an", 16'(an), 16'h000E);
        chk("f0_d0_hex", 16'(hex), 16'h4);
        wait_pos(20);
        chk("f0_d3_an", 16'(an), 16'h0007);
        chk("f0_d3_hex", 16'(hex), 16'h1);
        wait_pos(0);
        chk("f1_fd", 16'(frame_done), 16'h1);
        step();
        chk("f1_fd_gone", 16'(frame_done), 16'h0);

        // Pending value waits for the frame boundary; leading zeros dark.
        do_load(16'h0042, 4'b0000);
        chk("p42_busy", 16'(busy), 16'h1);
        wait_pos(0);
        chk("p42_busy_clr", 16'(busy), 16'h0);
        wait_pos(8);
        chk("p42_d1_an", 16'(an), 16'h000D);
        chk("p42_d1_hex", 16'(hex), 16'h4);
        wait_pos(14);
        chk("p42_d2_dark", 16'(an), 16'h000F);
        wait_pos(20);
        chk("p42_d3_dark", 16'(an), 16'h000F);

        // Non-BCD nibble sets err and stays dark; BCD value clears it.
        wait_pos(3);
        do_load(16'h12A4, 4'b0000);
        wait_pos(0);
        chk("bad_err", 16'(err), 16'h1);
        wait_pos(9);
        chk("bad_d1_an", 16'(an), 16'h000F);
        wait_pos(2);
        do_load(16'h0000, 4'b0000);
        wait_pos(0);
        chk("zero_err", 16'(err), 16'h0);
        wait_pos(3);
        chk("zero_d0_an", 16'(an), 16'h000E);
        chk("zero_d0_hex", 16'(hex), 16'h0);
        wait_pos(15);
        chk("zero_d2_an", 16'(an), 16'h000F);

        // Last load wins; decimal points.
        wait_pos(4);
        do_load(16'h1111, 4'b0000);
        wait_pos(10);
        do_load(16'h2222, 4'b0101);
        wait_pos(0);
        wait_pos(9);
        chk("lw_d1_an", 16'(an), 16'h000D);
        chk("lw_d1_hex", 16'(hex), 16'h2);
        chk("lw_d1_dp", 16'(dp), 16'h1);
        wait_pos(3);
        chk("lw_d0_dp", 16'(dp), 16'h0);

        // Load on the boundary edge bypasses to the display.
        wait_pos(23);
        do_load(16'h5678, 4'b0000);
        chk("byp_busy", 16'(busy), 16'h0);
        step();
        chk("byp_hex", 16'(hex), 16'h8);
        wait_pos(3);
        chk("byp_d0_an", 16'(an), 16'h000E);

        // Inner zero below a nonzero digit is shown.
        wait_pos(5);
        do_load(16'h1034, 4'b0000);
        wait_pos(0);
        wait_pos(15);
        chk("iz_d2_an", 16'(an), 16'h000B);
        chk("iz_d2_hex", 16'(hex), 16'h0);

        // Disable during digit 2 SHOW, then restart.
        enable = 1'b0;
        step();
        chk("dis_an", 16'(an), 16'h000F);
        chk("dis_fd", 16'(frame_done), 16'h0);
        step();
        enable = 1'b1;
        step();
        chk("re_an", 16'(an), 16'h000F);
        chk("re_hex", 16'(hex), 16'h4);
        wait_pos(2);
        chk("re_d0_an", 16'(an), 16'h000E);

        // Disable on the boundary edge: no frame pulse.
        wait_pos(23);
        enable = 1'b0;
        step();
        chk("disb_fd", 16'(frame_done), 16'h0);
        enable = 1'b1;
        step();

        // Reset mid-SHOW discards a pending value.
        wait_pos(8);
        do_load(16'h9999, 4'b0000);
        chk("rs_busy", 16'(busy), 16'h1);
        reset = 1'b1;
        model_reset();
        #1;
        chk("rs_an", 16'(an), 16'h000F);
        chk("rs_hex", 16'(hex), 16'h0);
        chk("rs_dp", 16'(dp), 16'h1);
        chk("rs_busy0", 16'(busy), 16'h0);
        step();
        step();
        reset = 1'b0;
        step();
        wait_pos(3);
        chk("rs_d0_an", 16'(an), 16'h000E);
        chk("rs_d0_hex", 16'(hex), 16'h0);
        wait_pos(9);
        chk("rs_d1_an", 16'(an), 16'h000F);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
